// File: rtl/sync_fifo_pkg.sv
// Shared constants and the depth lookup for the single-clock FIFO.
// Depths follow the 7-series block-RAM FIFO aspect ratios.
package sync_fifo_pkg;

    localparam int READY_DELAY = 4;

    localparam logic [55:0] DEVICE_7SERIES = "7SERIES";
    localparam logic [31:0] SIZE_18KB      = "18Kb";
    localparam logic [31:0] SIZE_36KB      = "36Kb";

    // A 36Kb primitive has twice the depth of an 18Kb one at every width.
    function automatic int fifo_depth(input logic [31:0] size, input int width);
        int d;
        if (width <= 4)       d = 4096;
        else if (width <= 9)  d = 2048;
        else if (width <= 18) d = 1024;
        else if (width <= 36) d = 512;
        else                  d = 256;
        if (size == SIZE_36KB) d = d * 2;
        return d;
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port with enable.
// The read register has a synchronous reset so the output starts at zero.
module sync_fifo_ram #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Read-before-write: a same-address write this edge is not seen until later.
    always_ff @(posedge clk) begin
        if (rst)        rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, occupancy count, registered flags, ready
// holdoff after reset and an optional output register over sync_fifo_ram.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter        DEVICE     = "7SERIES",
    parameter int    FIFO_WIDTH = 32,
    parameter        FIFO_SIZE  = "18Kb",
    parameter bit    DO_REG     = 1'b1,
    parameter bit    DEBUG      = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [FIFO_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [FIFO_WIDTH-1:0] rd_data,
    output logic                  ready,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = fifo_depth(FIFO_SIZE, FIFO_WIDTH);
    localparam int AW    = $clog2(DEPTH);
    localparam logic [AW:0] CNT_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE   = (AW+1)'(1);
    localparam logic [2:0]  RDY_LAST  = 3'(READY_DELAY);

    if (DEVICE != DEVICE_7SERIES) begin : g_bad_device
        $error("sync_fifo: unsupported DEVICE");
    end
    if ((FIFO_SIZE != SIZE_18KB && FIFO_SIZE != SIZE_36KB) || FIFO_WIDTH < 1 || FIFO_WIDTH > 72 ||
        (FIFO_WIDTH > 36 && FIFO_SIZE != SIZE_36KB)) begin : g_bad_geometry
        $error("sync_fifo: illegal FIFO_SIZE/FIFO_WIDTH combination");
    end

    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [AW:0]           count, count_next;
    logic [2:0]            ready_cnt;
    logic                  do_wr, do_rd;
    logic [FIFO_WIDTH-1:0] ram_q;

    // A full FIFO can still take a write when a read frees a slot this edge.
    assign do_rd = rd_en && ready && !empty;
    assign do_wr = wr_en && ready && (!full || do_rd);

    always_comb begin
        count_next = count;
        if (do_wr && !do_rd)      count_next = count + CNT_ONE;
        else if (do_rd && !do_wr) count_next = count - CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            full  <= (count_next == CNT_DEPTH);
            empty <= (count_next == '0);
        end
    end

    // ready rises on the edge after the counter has seen READY_DELAY clean cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_cnt <= '0;
            ready     <= 1'b0;
        end else begin
            if (ready_cnt != RDY_LAST) ready_cnt <= ready_cnt + 1'b1;
            ready <= (ready_cnt == RDY_LAST);
        end
    end

    sync_fifo_ram #(
        .WIDTH  (FIFO_WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (AW)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (do_wr),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_en   (do_rd),
        .rd_addr (rd_ptr),
        .rd_data (ram_q)
    );

    if (DO_REG) begin : g_out_reg
        logic                  rd_pending;
        logic [FIFO_WIDTH-1:0] out_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                rd_pending <= 1'b0;
                out_q      <= '0;
            end else begin
                rd_pending <= do_rd;
                if (rd_pending) out_q <= ram_q;
            end
        end
        assign rd_data = out_q;
    end else begin : g_out_direct
        assign rd_data = ram_q;
    end

    if (DEBUG) begin : g_debug
        always_ff @(posedge clk) begin
            if (!rst && ready && wr_en && full && !do_rd)
                $display("sync_fifo: overflow attempt ignored at %0t", $time);
            if (!rst && ready && rd_en && empty)
                $display("sync_fifo: underflow attempt ignored at %0t", $time);
        end
    end

endmodule

// File: tb/tb_sync_fifo.sv
// Drives one registered-output and one direct-output FIFO with shared stimulus
// and compares both against a queue-based reference model every cycle.
module tb_sync_fifo;

    localparam int DEPTH = 512;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic        rd_en = 1'b0;
    logic [31:0] rd_data_r, rd_data_c;
    logic        ready_r, full_r, empty_r;
    logic        ready_c, full_c, empty_c;

    int n_compared = 0;
    int n_mismatched = 0;

    logic [31:0] sb [$];
    logic [31:0] m_exp0 = '0, m_exp1 = '0, m_pend = '0;
    logic        m_pend_v = 1'b0, m_ready = 1'b0, model_live = 1'b0;
    logic        acc_rd, acc_wr;
    int          m_edges = 0;

    always #5 clk = ~clk;

    sync_fifo #(.FIFO_WIDTH(32), .FIFO_SIZE("18Kb"), .DO_REG(1'b1), .DEBUG(1'b1)) u_fifo_reg (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data_r), .ready(ready_r), .full(full_r), .empty(empty_r)
    );

    sync_fifo #(.FIFO_WIDTH(32), .FIFO_SIZE("18Kb"), .DO_REG(1'b0), .DEBUG(1'b0)) u_fifo_comb (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data_c), .ready(ready_c), .full(full_c), .empty(empty_c)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic w, input logic [31:0] d, input logic r);
        @(negedge clk);
        #1;
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
    endtask

    // Reference: writes are queued as accepted, reads pop the expected word.
    always @(posedge clk) begin
        if (rst) begin
            sb.delete();
            m_exp0 = '0; m_exp1 = '0; m_pend_v = 1'b0;
            m_edges = 0; m_ready = 1'b0;
        end else begin
            acc_rd = rd_en && m_ready && (sb.size() != 0);
            acc_wr = wr_en && m_ready && ((sb.size() != DEPTH) || acc_rd);
            if (m_pend_v) m_exp1 = m_pend;
            m_pend_v = acc_rd;
            if (acc_rd) begin
                m_pend = sb.pop_front();
                m_exp0 = m_pend;
            end
            if (acc_wr) sb.push_back(wr_data);
            if (m_edges < 100) m_edges++;
            m_ready = (m_edges >= 5);
        end
        model_live = 1'b1;
    end

    always @(negedge clk) begin
        if (model_live) begin
            checkOutput("rd_data_reg", 64'(rd_data_r), 64'(m_exp1));
            checkOutput("rd_data_comb", 64'(rd_data_c), 64'(m_exp0));
            checkOutput("empty_reg", 64'(empty_r), 64'(sb.size() == 0));
            checkOutput("empty_comb", 64'(empty_c), 64'(sb.size() == 0));
            checkOutput("full_reg", 64'(full_r), 64'(sb.size() == DEPTH));
            checkOutput("full_comb", 64'(full_c), 64'(sb.size() == DEPTH));
            checkOutput("ready_reg", 64'(ready_r), 64'(m_ready));
            checkOutput("ready_comb", 64'(ready_c), 64'(m_ready));
        end
    end

    initial begin
        logic [31:0] words [3];
        int ready_edge;

        repeat (6) @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("reset_empty", 64'(empty_r), 64'd1);
        checkOutput("reset_full", 64'(full_r), 64'd0);
        checkOutput("reset_ready", 64'(ready_r), 64'd0);
        checkOutput("reset_rd_data", 64'(rd_data_r), 64'd0);
        checkOutput("reset_rd_data_comb", 64'(rd_data_c), 64'd0);
        rst = 1'b0;

        ready_edge = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (ready_r) begin
                ready_edge = i;
                break;
            end
        end
        checkOutput("ready_rise_edge", 64'(ready_edge), 64'd5);

        for (int i = 0; i < 3; i++) words[i] = $urandom;
        applyStimulus(1'b1, words[0], 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("empty_after_A", 64'(empty_r), 64'd0);
        applyStimulus(1'b1, words[1], 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        applyStimulus(1'b1, words[2], 1'b0);
        applyStimulus(1'b0, '0, 1'b0);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, '0, 1'b1);
            applyStimulus(1'b0, '0, 1'b0);
            checkOutput("latency1_word", 64'(rd_data_c), 64'(words[i]));
            applyStimulus(1'b0, '0, 1'b0);
            checkOutput("latency2_word", 64'(rd_data_r), 64'(words[i]));
        end
        checkOutput("empty_after_3_reads", 64'(empty_r), 64'd1);

        // Pointers start at 3 here, so filling to DEPTH exercises the wrap.
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 32'(i), 1'b0);
        applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0);
        checkOutput("full_at_512", 64'(full_r), 64'd1);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("full_after_overflow", 64'(full_r), 64'd1);
        checkOutput("model_depth_after_overflow", 64'(sb.size()), 64'(DEPTH));
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, '0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("last_drained_word", 64'(rd_data_r), 64'(DEPTH - 1));
        checkOutput("empty_after_drain", 64'(empty_r), 64'd1);

        repeat (3) applyStimulus(1'b0, '0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("underflow_rd_data", 64'(rd_data_r), 64'(DEPTH - 1));
        checkOutput("underflow_empty", 64'(empty_r), 64'd1);

        applyStimulus(1'b1, 32'hA000_0000, 1'b0);
        for (int i = 1; i <= 10; i++) applyStimulus(1'b1, 32'hA000_0000 + 32'(i), 1'b1);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("rw_hold_empty", 64'(empty_r), 64'd0);
        checkOutput("rw_hold_full", 64'(full_r), 64'd0);
        checkOutput("rw_hold_depth", 64'(sb.size()), 64'd1);
        applyStimulus(1'b0, '0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("rw_last_word", 64'(rd_data_r), 64'h0000_0000_A000_000A);

        for (int i = 0; i < 4; i++) applyStimulus(1'b1, $urandom, 1'b0);
        applyStimulus(1'b0, '0, 1'b1);
        rst = 1'b1;
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("empty_after_mid_reset", 64'(empty_r), 64'd1);
        checkOutput("rd_data_after_mid_reset", 64'(rd_data_c), 64'd0);
        rst = 1'b0;
        repeat (6) applyStimulus(1'b0, '0, 1'b0);
        applyStimulus(1'b1, 32'h1234_5678, 1'b0);
        applyStimulus(1'b0, '0, 1'b1);
        repeat (3) applyStimulus(1'b0, '0, 1'b0);
        checkOutput("post_reset_word", 64'(rd_data_r), 64'h0000_0000_1234_5678);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
